// File: rtl/ppu_if_pkg.sv
// Shared opcode encodings, OAM byte-enable patterns and queue-entry sizing
// for the CPU-to-PPU write path.
package ppu_if_pkg;

   localparam logic [3:0] SRM = 4'h1;
   localparam logic [3:0] SSL = 4'h2;
   localparam logic [3:0] SLD = 4'h3;
   localparam logic [3:0] SFT = 4'h4;
   localparam logic [3:0] SBT = 4'h5;
   localparam logic [3:0] SFA = 4'h6;
   localparam logic [3:0] SBA = 4'h7;

   localparam logic [3:0] OAM_BE_NONE = 4'b0000;
   localparam logic [3:0] OAM_BE_ALL  = 4'b1111;
   localparam logic [3:0] OAM_BE_SSL  = 4'b1001;
   localparam logic [3:0] OAM_BE_SFT  = 4'b0010;
   localparam logic [3:0] OAM_BE_SFA  = 4'b0100;

   localparam int unsigned OP_W = 3;

   // Queue entries are packed as {op[2:0], index, value}.
   function automatic int unsigned entry_w(int unsigned bg_w, int unsigned data_w);
      return OP_W + bg_w + data_w;
   endfunction

endpackage

// File: rtl/ppu_write_decode.sv
// Combinational decode of one queued S-type write into PPU strobes, addresses
// and data; all fields are zero when valid_i is low.
module ppu_write_decode
   import ppu_if_pkg::*;
#(
   parameter int unsigned OAM_ADDR_W = 6,
   parameter int unsigned BG_ADDR_W  = 10,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  valid_i,
   input  logic [2:0]            op_i,
   input  logic [BG_ADDR_W-1:0]  index_i,
   input  logic [DATA_W-1:0]     value_i,
   output logic                  bgtt_o,
   output logic                  bgat_o,
   output logic [BG_ADDR_W-1:0]  bg_addr_o,
   output logic [7:0]            bg_data_o,
   output logic [3:0]            oam_be_o,
   output logic [OAM_ADDR_W-1:0] oam_addr_o,
   output logic [31:0]           oam_data_o
);

   always_comb begin
      bgtt_o     = 1'b0;
      bgat_o     = 1'b0;
      bg_addr_o  = '0;
      bg_data_o  = '0;
      oam_be_o   = OAM_BE_NONE;
      oam_addr_o = '0;
      oam_data_o = '0;
      if (valid_i) begin
         oam_addr_o = index_i[OAM_ADDR_W-1:0];
         bg_addr_o  = index_i;
         bg_data_o  = value_i[7:0];
         case ({1'b0, op_i})
            SRM: begin
               oam_be_o   = OAM_BE_ALL;
               oam_data_o = '1;
            end
            SSL: begin
               oam_be_o   = OAM_BE_SSL;
               oam_data_o = {value_i[15:8], 8'h00, 8'h00, value_i[7:0]};
            end
            SLD: begin
               oam_be_o   = OAM_BE_ALL;
               oam_data_o = value_i[31:0];
            end
            SFT: begin
               oam_be_o   = OAM_BE_SFT;
               oam_data_o = {8'h00, 8'h00, value_i[7:0], 8'h00};
            end
            SFA: begin
               oam_be_o   = OAM_BE_SFA;
               oam_data_o = {8'h00, value_i[7:0], 8'h00, 8'h00};
            end
            SBT:     bgtt_o = 1'b1;
            SBA:     bgat_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cpu_ppu_write_queue.sv
// FIFO between CPU EX-stage PPU writes and the PPU memories, drained only while
// the write window is open. Optional macro: CPU_PPU_WQ_BYPASS_EN.
module cpu_ppu_write_queue
   import ppu_if_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned OAM_ADDR_W = 6,
   parameter int unsigned BG_ADDR_W  = 10,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [3:0]                 opcode,
   input  logic [BG_ADDR_W-1:0]       S_type_index,
   input  logic [DATA_W-1:0]          S_type_value,
   input  logic                       ppu_write_window,
   output logic                       cpu_stall,
   output logic                       queue_empty,
   output logic [$clog2(DEPTH):0]     queue_count,
   output logic                       overflow,
   output logic                       BGTTWrite,
   output logic                       BGATWrite,
   output logic [BG_ADDR_W-1:0]       BGWrite_addr,
   output logic [7:0]                 BGWrite_data,
   output logic [3:0]                 OAMWrite,
   output logic [OAM_ADDR_W-1:0]      OAMWrite_addr,
   output logic [31:0]                OAMWrite_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = entry_w(BG_ADDR_W, DATA_W);

   logic [EW-1:0]  mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q;
   logic           full, valid_op, bypass, push, pop;
   logic [EW-1:0]  in_entry, head_entry, dec_entry;

   logic                  bgtt_d, bgat_d, bgtt_q, bgat_q;
   logic [BG_ADDR_W-1:0]  bg_addr_d, bg_addr_q;
   logic [7:0]            bg_data_d, bg_data_q;
   logic [3:0]            oam_be_d, oam_be_q;
   logic [OAM_ADDR_W-1:0] oam_addr_d, oam_addr_q;
   logic [31:0]           oam_data_d, oam_data_q;

   assign full       = (count_q == CW'(DEPTH));
   assign valid_op   = enable && (opcode != 4'h0) && !opcode[3];
   assign in_entry   = {opcode[2:0], S_type_index, S_type_value};
   assign head_entry = mem_q[rd_ptr_q];

`ifdef CPU_PPU_WQ_BYPASS_EN
   // An empty queue with an open window lets the request go straight to decode.
   assign bypass = valid_op && (count_q == '0) && ppu_write_window;
`else
   assign bypass = 1'b0;
`endif

   assign push      = valid_op && !full && !bypass;
   assign pop       = ppu_write_window && (count_q != '0);
   assign dec_entry = bypass ? in_entry : head_entry;
   assign count_d   = count_q + CW'(push) - CW'(pop);

   ppu_write_decode #(
      .OAM_ADDR_W (OAM_ADDR_W),
      .BG_ADDR_W  (BG_ADDR_W),
      .DATA_W     (DATA_W)
   ) u_decode (
      .valid_i    (pop || bypass),
      .op_i       (dec_entry[EW-1 -: OP_W]),
      .index_i    (dec_entry[DATA_W +: BG_ADDR_W]),
      .value_i    (dec_entry[DATA_W-1:0]),
      .bgtt_o     (bgtt_d),
      .bgat_o     (bgat_d),
      .bg_addr_o  (bg_addr_d),
      .bg_data_o  (bg_data_d),
      .oam_be_o   (oam_be_d),
      .oam_addr_o (oam_addr_d),
      .oam_data_o (oam_data_d)
   );

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         bgtt_q     <= 1'b0;
         bgat_q     <= 1'b0;
         bg_addr_q  <= '0;
         bg_data_q  <= '0;
         oam_be_q   <= '0;
         oam_addr_q <= '0;
         oam_data_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         if (valid_op && full) overflow_q <= 1'b1;
         bgtt_q     <= bgtt_d;
         bgat_q     <= bgat_d;
         bg_addr_q  <= bg_addr_d;
         bg_data_q  <= bg_data_d;
         oam_be_q   <= oam_be_d;
         oam_addr_q <= oam_addr_d;
         oam_data_q <= oam_data_d;
      end
   end

   assign cpu_stall     = full;
   assign queue_empty   = (count_q == '0);
   assign queue_count   = count_q;
   assign overflow      = overflow_q;
   assign BGTTWrite     = bgtt_q;
   assign BGATWrite     = bgat_q;
   assign BGWrite_addr  = bg_addr_q;
   assign BGWrite_data  = bg_data_q;
   assign OAMWrite      = oam_be_q;
   assign OAMWrite_addr = oam_addr_q;
   assign OAMWrite_data = oam_data_q;

endmodule
